aesl_axis_block_detector: RTL and testbench
===========================================

Name: aesl_axis_block_detector

Overview:
- Producer side of the cosim deadlock-monitor interface: watches the DUT's AXI-Stream ports and generates the per-port `axis_block_sigs` vector that the dataflow deadlock monitors consume.
- A port is flagged blocked only after it has stalled for a programmable number of consecutive cycles.
- Also keeps sticky diagnostics (which ports blocked, first port to block, block-event count) for the end-of-simulation deadlock report.
- Simulation-only block, instantiated in the cosim top next to the monitor hierarchy.

Parameters:
- NUM_IN, 1, number of DUT input AXIS ports (DUT is consumer).
- NUM_OUT, 1, number of DUT output AXIS ports (DUT is producer).
- STALL_THRESH, 16, consecutive stalled cycles before a port is flagged blocked; legal range 1..65535.
- CNT_W, 16, width of the block-event counter.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- dut_start  in  1  pulse: DUT run begins.
- dut_done  in  1  pulse: DUT run ends.
- in_tvalid  in  NUM_IN  TVALID of each DUT input stream (driven by testbench).
- in_tready  in  NUM_IN  TREADY of each DUT input stream (driven by DUT).
- out_tvalid  in  NUM_OUT  TVALID of each DUT output stream (driven by DUT).
- out_tready  in  NUM_OUT  TREADY of each DUT output stream (driven by testbench).
- axis_block_sigs  out  NUM_IN+NUM_OUT  per-port blocked flag. Bits [NUM_IN-1:0] are the inputs; the remaining bits above them are the outputs.
- block_info  out  NUM_IN+NUM_OUT  sticky OR of axis_block_sigs for the current run.
- first_block_vld  out  1  a first-block index has been captured this run.
- first_block_idx  out  16  bit index of the first port to assert blocked this run.
- block_events  out  CNT_W  count of rising edges across all axis_block_sigs bits; saturating.
- active  out  1  high while in RUN.

Behaviour:
- Reset, sampled on posedge clock while reset=1:
  - State goes to IDLE.
  - All stall counters are set to 0.
  - All outputs are set to 0.
- Reset asserted mid-run behaves identically; there is no partial retention.
- State machine:
  - IDLE: dut_start → RUN.
  - RUN: dut_done → DONE. dut_start is ignored in RUN. If dut_start and dut_done arrive in the same cycle, dut_done wins.
  - DONE: dut_start → RUN.
  - On entry to RUN (the edge that transitions into it), clear block_info, first_block_vld, first_block_idx and block_events.
  - active=1 exactly while the state is RUN.
- Stall definition, evaluated only in RUN:
  - Input port i is stalled when in_tready[i]=1 and in_tvalid[i]=0 (DUT starved).
  - Output port j is stalled when out_tvalid[j]=1 and out_tready[j]=0 (DUT back-pressured).
  - A handshake (valid and ready both 1) or both signals low is not stalled.
- Per-port stall counter:
  - Width is clog2(STALL_THRESH+1).
  - In RUN with the port stalled: increment, saturating at STALL_THRESH.
  - Port not stalled, or state not RUN: next value is 0.
- axis_block_sigs[k] is registered: next value = RUN and stalled(k) and cnt(k) ≥ STALL_THRESH-1.
  - Counting the first stalled cycle as cycle 0, the flag is first high in cycle STALL_THRESH.
  - For STALL_THRESH=1 it is high in cycle 1.
  - The flag drops one cycle after the first non-stalled cycle.
  - All flags drop one cycle after leaving RUN.
- block_info: next value = block_info | next axis_block_sigs while in RUN. It holds through DONE and is cleared only on the next RUN entry or on reset.
- first_block_idx and first_block_vld:
  - On the first cycle in a run where any axis_block_sigs bit rises while first_block_vld=0, capture the lowest index among the rising bits and set first_block_vld=1.
  - Both then hold until the next RUN entry.
- block_events:
  - Adds the popcount of rising bits in axis_block_sigs each cycle. Multiple simultaneous rises all count.
  - Saturates at 2^CNT_W-1 with no wrap, including when a multi-bit add would overflow.

Test Plan:
- Reset, then dut_start. Input 0 has tready=1 and tvalid=0 for 20 cycles, STALL_THRESH=16 → axis_block_sigs[0] rises in cycle 16 after stall start. block_info[0]=1, first_block_idx=0, block_events=1. The flag falls 1 cycle after tvalid=1.
- Output stall for 15 cycles, then a handshake, then another 15-cycle stall → axis_block_sigs never asserts and block_events=0, because the counter resets on the handshake.
- Input 0 and output 0 become stalled in the same cycle → both flags rise in the same cycle. first_block_idx=0, block_events=2.
- Output blocked in RUN, then dut_done pulse → flags clear one cycle later. block_info is held through DONE. The next dut_start clears block_info, first_block_vld and block_events to 0.
- CNT_W=2 with 5 block/unblock episodes → block_events saturates at 3.
- Reset asserted while a port is blocked in RUN → all outputs are 0 the cycle after, and the state is IDLE. dut_start in the same cycle as dut_done while in RUN → state DONE.

Source files
------------

// File: rtl/aesl_axis_block_detector.sv
// aesl_axis_block_detector: flags AXI-Stream ports that stay stalled for STALL_THRESH cycles.
// Also keeps sticky per-run diagnostics for the deadlock report. Rev 1.0.
`timescale 1ns/1ps
`default_nettype none

module aesl_axis_block_detector #(
    parameter int NUM_IN       = 1,
    parameter int NUM_OUT      = 1,
    parameter int STALL_THRESH = 16,
    parameter int CNT_W        = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       dut_start,
    input  logic                       dut_done,
    input  logic [NUM_IN-1:0]          in_tvalid,
    input  logic [NUM_IN-1:0]          in_tready,
    input  logic [NUM_OUT-1:0]         out_tvalid,
    input  logic [NUM_OUT-1:0]         out_tready,
    output logic [NUM_IN+NUM_OUT-1:0]  axis_block_sigs,
    output logic [NUM_IN+NUM_OUT-1:0]  block_info,
    output logic                       first_block_vld,
    output logic [15:0]                first_block_idx,
    output logic [CNT_W-1:0]           block_events,
    output logic                       active
);

    localparam int NUM_PORTS   = NUM_IN + NUM_OUT;
    localparam int STALL_CNT_W = $clog2(STALL_THRESH + 1);
    localparam int SUM_W       = CNT_W + $clog2(NUM_PORTS + 1);

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = STALL_CNT_W'(STALL_THRESH);
    localparam logic [STALL_CNT_W-1:0] BLK_AT    = STALL_CNT_W'(STALL_THRESH - 1);
    localparam logic [CNT_W-1:0]       EV_MAX    = '1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic                 run;
    logic                 run_entry;
    logic [NUM_PORTS-1:0] stalled;
    logic [NUM_PORTS-1:0] blk_next;
    logic [NUM_PORTS-1:0] rise;
    logic [SUM_W-1:0]     ev_sum;
    logic [CNT_W-1:0]     events_next;
    logic [15:0]          idx_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // dut_done is tested first in RUN so it wins over a coincident dut_start
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (dut_start) state_next = S_RUN;
            S_RUN:   if (dut_done)  state_next = S_DONE;
            S_DONE:  if (dut_start) state_next = S_RUN;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        run       = (state == S_RUN);
        run_entry = (state != S_RUN) && (state_next == S_RUN);
        active    = run;
    end

    // Inputs stall when the DUT is starved, outputs when it is back-pressured
    assign stalled = {out_tvalid & ~out_tready, in_tready & ~in_tvalid};

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        logic [STALL_CNT_W-1:0] cnt;

        always_ff @(posedge clock) begin
            if (reset) begin
                cnt <= '0;
            end else if (run && stalled[k]) begin
                if (cnt < STALL_MAX) begin
                    cnt <= cnt + STALL_CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end

        assign blk_next[k] = run && stalled[k] && (cnt >= BLK_AT);
    end

    assign rise = blk_next & ~axis_block_sigs;

    // Saturating multi-bit add; the wider sum keeps overflow visible
    always_comb begin
        ev_sum = SUM_W'(block_events);
        for (int k = 0; k < NUM_PORTS; k++) begin
            ev_sum = ev_sum + SUM_W'(rise[k]);
        end
        if (ev_sum > SUM_W'(EV_MAX)) begin
            events_next = EV_MAX;
        end else begin
            events_next = ev_sum[CNT_W-1:0];
        end
    end

    always_comb begin
        idx_next = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (rise[k]) idx_next = 16'(k);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            axis_block_sigs <= '0;
            block_info      <= '0;
            first_block_vld <= 1'b0;
            first_block_idx <= '0;
            block_events    <= '0;
        end else begin
            axis_block_sigs <= blk_next;
            if (run_entry) begin
                block_info      <= '0;
                first_block_vld <= 1'b0;
                first_block_idx <= '0;
                block_events    <= '0;
            end else if (run) begin
                block_info   <= block_info | blk_next;
                block_events <= events_next;
                if (!first_block_vld && (|rise)) begin
                    first_block_vld <= 1'b1;
                    first_block_idx <= idx_next;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aesl_axis_block_detector.sv
// tb_aesl_axis_block_detector: directed scoreboard bench; a second instance with CNT_W=2
// shares all stimulus to exercise counter saturation. Rev 1.0.
`timescale 1ns/1ps
`default_nettype none

module tb_aesl_axis_block_detector;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        dut_start = 1'b0;
    logic        dut_done = 1'b0;
    logic [0:0]  in_tvalid = '0;
    logic [0:0]  in_tready = '0;
    logic [0:0]  out_tvalid = '0;
    logic [0:0]  out_tready = '0;

    logic [1:0]  sigs_a, info_a, sigs_b, info_b;
    logic        vld_a, vld_b, act_a, act_b;
    logic [15:0] idx_a, idx_b;
    logic [15:0] ev_a;
    logic [1:0]  ev_b;

    always #5 clock = ~clock;

    aesl_axis_block_detector #(
        .NUM_IN(1), .NUM_OUT(1), .STALL_THRESH(16), .CNT_W(16)
    ) u_dut (
        .clock(clock), .reset(reset), .dut_start(dut_start), .dut_done(dut_done),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .axis_block_sigs(sigs_a), .block_info(info_a),
        .first_block_vld(vld_a), .first_block_idx(idx_a),
        .block_events(ev_a), .active(act_a)
    );

    aesl_axis_block_detector #(
        .NUM_IN(1), .NUM_OUT(1), .STALL_THRESH(16), .CNT_W(2)
    ) u_dut_sat (
        .clock(clock), .reset(reset), .dut_start(dut_start), .dut_done(dut_done),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .axis_block_sigs(sigs_b), .block_info(info_b),
        .first_block_vld(vld_b), .first_block_idx(idx_b),
        .block_events(ev_b), .active(act_b)
    );

    typedef struct packed {
        logic [1:0]  sigs;
        logic [1:0]  info;
        logic        vld;
        logic [15:0] idx;
        logic [15:0] ev;
        logic [1:0]  ev2;
        logic        act;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    exp_t  mon_e;
    string mon_nm;

    task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, got, want);
        end
    endtask

    // Expected outputs for the cycle just entered; the monitor checks them at the next negedge
    task automatic exp_push(input string nm, input logic [1:0] sigs, input logic [1:0] info,
                            input logic vld, input logic [15:0] idx, input logic [15:0] ev,
                            input logic act);
        exp_t e;
        e.sigs = sigs; e.info = info; e.vld = vld; e.idx = idx; e.ev = ev; e.act = act;
        e.ev2  = (ev > 16'd3) ? 2'd3 : ev[1:0];
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            chk(mon_nm, "sigs",   32'(sigs_a), 32'(mon_e.sigs));
            chk(mon_nm, "info",   32'(info_a), 32'(mon_e.info));
            chk(mon_nm, "vld",    32'(vld_a),  32'(mon_e.vld));
            chk(mon_nm, "idx",    32'(idx_a),  32'(mon_e.idx));
            chk(mon_nm, "events", 32'(ev_a),   32'(mon_e.ev));
            chk(mon_nm, "active", 32'(act_a),  32'(mon_e.act));
            chk(mon_nm, "sat_events", 32'(ev_b), 32'(mon_e.ev2));
            chk(mon_nm, "sat_sigs",   32'(sigs_b), 32'(mon_e.sigs));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ports(input logic itv, input logic itr, input logic otv, input logic otr);
        in_tvalid = itv; in_tready = itr; out_tvalid = otv; out_tready = otr;
    endtask

    task automatic pulse_start();
        dut_start = 1'b1;
        step();
        dut_start = 1'b0;
    endtask

    task automatic pulse_done();
        dut_done = 1'b1;
        step();
        dut_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ev_tab [5];
        ev_tab[0] = 16'd1; ev_tab[1] = 16'd2; ev_tab[2] = 16'd4; ev_tab[3] = 16'd5; ev_tab[4] = 16'd6;

        // Reset state
        step(); step();
        exp_push("reset", 2'b00, 2'b00, 1'b0, 16'd0, 16'd0, 1'b0);
        reset = 1'b0;
        step();
        pulse_start();
        exp_push("run_entry", 2'b00, 2'b00, 1'b0, 16'd0, 16'd0, 1'b1);

        // Input 0 starved: flag first high 16 cycles after stall start
        set_ports(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i >= 16) exp_push("in_stall", 2'b01, 2'b01, 1'b1, 16'd0, 16'd1, 1'b1);
            else         exp_push("in_stall", 2'b00, 2'b00, 1'b0, 16'd0, 16'd0, 1'b1);
        end
        set_ports(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        exp_push("in_release", 2'b00, 2'b01, 1'b1, 16'd0, 16'd1, 1'b1);
        set_ports(1'b0, 1'b0, 1'b0, 1'b0);

        pulse_done();
        exp_push("done_hold", 2'b00, 2'b01, 1'b1, 16'd0, 16'd1, 1'b0);
        pulse_start();
        exp_push("restart_clear", 2'b00, 2'b00, 1'b0, 16'd0, 16'd0, 1'b1);

        // Two 15-cycle output stalls split by a handshake never block
        set_ports(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            step();
            exp_push("out15_a", 2'b00, 2'b00, 1'b0, 16'd0, 16'd0, 1'b1);
        end
        set_ports(1'b0, 1'b0, 1'b1, 1'b1);
        step();
        exp_push("out_hs", 2'b00, 2'b00, 1'b0, 16'd0, 16'd0, 1'b1);
        set_ports(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            step();
            exp_push("out15_b", 2'b00, 2'b00, 1'b0, 16'd0, 16'd0, 1'b1);
        end
        set_ports(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        exp_push("out15_idle", 2'b00, 2'b00, 1'b0, 16'd0, 16'd0, 1'b1);

        // Input and output stall together: simultaneous rises both count
        set_ports(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 16) exp_push("both_stall", 2'b11, 2'b11, 1'b1, 16'd0, 16'd2, 1'b1);
            else         exp_push("both_stall", 2'b00, 2'b00, 1'b0, 16'd0, 16'd0, 1'b1);
        end

        // dut_done while blocked: flags persist one cycle, then clear; diagnostics held
        pulse_done();
        exp_push("done_blk1", 2'b11, 2'b11, 1'b1, 16'd0, 16'd2, 1'b0);
        step();
        exp_push("done_blk2", 2'b00, 2'b11, 1'b1, 16'd0, 16'd2, 1'b0);
        set_ports(1'b0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        exp_push("restart2", 2'b00, 2'b00, 1'b0, 16'd0, 16'd0, 1'b1);

        // Output-only block captures index 1
        set_ports(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 16) exp_push("out_blk", 2'b10, 2'b10, 1'b1, 16'd1, 16'd1, 1'b1);
            else if (i == 15) exp_push("out_blk", 2'b00, 2'b00, 1'b0, 16'd0, 16'd0, 1'b1);
        end
        set_ports(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        exp_push("out_rel", 2'b00, 2'b10, 1'b1, 16'd1, 16'd1, 1'b1);

        // Coincident start and done in RUN: done wins
        dut_start = 1'b1;
        pulse_done();
        dut_start = 1'b0;
        exp_push("start_done", 2'b00, 2'b10, 1'b1, 16'd1, 16'd1, 1'b0);
        pulse_start();
        exp_push("restart3", 2'b00, 2'b00, 1'b0, 16'd0, 16'd0, 1'b1);

        // Five episodes; the third blocks both ports to overflow the 2-bit counter by two
        for (int e = 0; e < 5; e++) begin
            if (e == 2) set_ports(1'b0, 1'b1, 1'b1, 1'b0);
            else        set_ports(1'b0, 1'b0, 1'b1, 1'b0);
            repeat (16) step();
            exp_push("episode", (e == 2) ? 2'b11 : 2'b10, (e >= 2) ? 2'b11 : 2'b10,
                     1'b1, 16'd1, ev_tab[e], 1'b1);
            set_ports(1'b0, 1'b0, 1'b0, 1'b0);
            step();
            exp_push("episode_rel", 2'b00, (e >= 2) ? 2'b11 : 2'b10, 1'b1, 16'd1, ev_tab[e], 1'b1);
        end

        // Reset while blocked, then a stall in IDLE must not count
        set_ports(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (16) step();
        exp_push("pre_reset", 2'b10, 2'b11, 1'b1, 16'd1, 16'd7, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_push("mid_reset", 2'b00, 2'b00, 1'b0, 16'd0, 16'd0, 1'b0);
        repeat (17) step();
        exp_push("idle_stall", 2'b00, 2'b00, 1'b0, 16'd0, 16'd0, 1'b0);
        set_ports(1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clock);
        #1;
        chk("drain", "queue", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
